// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_skid inter-stage register: state encoding,
// the default bubble instruction (addi x0,x0,0) and the default perf-counter width.
package pipe_pkg;

  localparam logic [31:0] BUBBLE_INST_DEF = 32'h00000013;
  localparam int unsigned CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
// Cleared only by the asynchronous reset.
module pipe_sat_cnt #(
  parameter int unsigned W = 32
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional feature macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W   = 64,
  parameter logic [31:0] BUBBLE_INST = BUBBLE_INST_DEF
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W       = CNT_W_DEF
`endif
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [31:0]          in_pc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_pc,
  output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  state_e                 state_q, state_d;
  logic [31:0]            main_inst_q, main_inst_d;
  logic [31:0]            main_pc_q, main_pc_d;
  logic [PAYLOAD_W-1:0]   main_payload_q, main_payload_d;
  logic [31:0]            skid_inst_q, skid_inst_d;
  logic [31:0]            skid_pc_q, skid_pc_d;
  logic [PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;

  logic in_ready_s;
  logic out_valid_s;
  logic in_fire_s;
  logic out_fire_s;

  // handshake decode depends only on state and ce, never on in_* data
  always_comb begin
    in_ready_s  = ce && (state_q != ST_FULL);
    out_valid_s = (state_q == ST_BUSY) || (state_q == ST_FULL);
    in_fire_s   = in_valid && in_ready_s;
    out_fire_s  = out_valid_s && out_ready && ce;
  end

  // next-state and datapath selection; flush overrides everything
  always_comb begin
    state_d        = state_q;
    main_inst_d    = main_inst_q;
    main_pc_d      = main_pc_q;
    main_payload_d = main_payload_q;
    skid_inst_d    = skid_inst_q;
    skid_pc_d      = skid_pc_q;
    skid_payload_d = skid_payload_q;
    if (flush) begin
      state_d        = ST_EMPTY;
      main_inst_d    = BUBBLE_INST;
      main_pc_d      = 32'h0000_0000;
      main_payload_d = {PAYLOAD_W{1'b0}};
      skid_inst_d    = 32'h0000_0000;
      skid_pc_d      = 32'h0000_0000;
      skid_payload_d = {PAYLOAD_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d        = ST_BUSY;
            main_inst_d    = in_inst;
            main_pc_d      = in_pc;
            main_payload_d = in_payload;
          end else begin
            state_d        = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_fire_s && !out_fire_s) begin
            state_d        = ST_FULL;
            skid_inst_d    = in_inst;
            skid_pc_d      = in_pc;
            skid_payload_d = in_payload;
          end else if (!in_fire_s && out_fire_s) begin
            state_d        = ST_EMPTY;
            main_inst_d    = BUBBLE_INST;
            main_pc_d      = 32'h0000_0000;
            main_payload_d = {PAYLOAD_W{1'b0}};
          end else if (in_fire_s && out_fire_s) begin
            state_d        = ST_BUSY;
            main_inst_d    = in_inst;
            main_pc_d      = in_pc;
            main_payload_d = in_payload;
          end else begin
            state_d        = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d        = ST_BUSY;
            main_inst_d    = skid_inst_q;
            main_pc_d      = skid_pc_q;
            main_payload_d = skid_payload_q;
          end else begin
            state_d        = ST_FULL;
          end
        end
        default: begin
          // unreachable encoding recovers to an empty stage
          state_d        = ST_EMPTY;
          main_inst_d    = BUBBLE_INST;
          main_pc_d      = 32'h0000_0000;
          main_payload_d = {PAYLOAD_W{1'b0}};
          skid_inst_d    = 32'h0000_0000;
          skid_pc_d      = 32'h0000_0000;
          skid_payload_d = {PAYLOAD_W{1'b0}};
        end
      endcase
    end
  end

  // state, head and skid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      main_inst_q    <= BUBBLE_INST;
      main_pc_q      <= 32'h0000_0000;
      main_payload_q <= {PAYLOAD_W{1'b0}};
      skid_inst_q    <= 32'h0000_0000;
      skid_pc_q      <= 32'h0000_0000;
      skid_payload_q <= {PAYLOAD_W{1'b0}};
    end else begin
      state_q        <= state_d;
      main_inst_q    <= main_inst_d;
      main_pc_q      <= main_pc_d;
      main_payload_q <= main_payload_d;
      skid_inst_q    <= skid_inst_d;
      skid_pc_q      <= skid_pc_d;
      skid_payload_q <= skid_payload_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_s;
  assign out_inst    = main_inst_q;
  assign out_pc      = main_pc_q;
  assign out_payload = main_payload_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ce && in_valid && !in_ready_s),
    .cnt (stall_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ce && !out_valid_s),
    .cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (counter checks under PIPE_STAGE_PERF_EN).
module tb_pipe_stage_skid;

  localparam int unsigned PW = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [PW-1:0] out_payload;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic [3:0]  stall4, bubble4;
  logic        in_ready4, out_valid4;
  logic [31:0] out_inst4, out_pc4;
  logic [PW-1:0] out_payload4;
`endif

  pipe_stage_skid #(.PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_payload(out_payload)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_skid #(.PAYLOAD_W(PW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_inst(in_inst), .in_pc(in_pc),
    .in_payload(in_payload), .out_valid(out_valid4), .out_ready(out_ready),
    .out_inst(out_inst4), .out_pc(out_pc4), .out_payload(out_payload4),
    .stall_cnt(stall4), .bubble_cnt(bubble4)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid   = v;
    in_pc      = pc;
    in_inst    = 32'hA000_0000 | pc;
    in_payload = {32'hC0DE_0000, pc};
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_pc"}, {32'd0, out_pc}, {32'd0, pc});
    check({tag, "_inst"}, {32'd0, out_inst}, {32'd0, 32'hA000_0000 | pc});
    check({tag, "_payload"}, out_payload, {32'hC0DE_0000, pc});
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_inst"}, {32'd0, out_inst}, {32'd0, NOP});
    check({tag, "_pc"}, {32'd0, out_pc}, 64'd0);
    check({tag, "_payload"}, out_payload, 64'd0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    #12;
    expect_empty("reset");
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst = 1'b0;
    #1;

`ifdef PIPE_STAGE_PERF_EN
    // 4 idle cycles + first push while empty = 5 bubbles; 3 stalled cycles while FULL
    for (int i = 0; i < 4; i++) tick();
    drive(1'b1, 32'h100); tick();
    drive(1'b1, 32'h104); tick();
    drive(1'b1, 32'h108);
    for (int i = 0; i < 3; i++) tick();
    check("perf_bubble", {32'd0, bubble_cnt}, 64'd5);
    check("perf_stall", {32'd0, stall_cnt}, 64'd3);
    drive(1'b0, 32'h0); flush = 1'b1; tick(); flush = 1'b0;
    check("perf_flush_keeps_stall", {32'd0, stall_cnt}, 64'd3);
    for (int i = 0; i < 20; i++) tick();
    check("perf_sat_bubble4", {60'd0, bubble4}, 64'hF);
    tick();
    check("perf_sat_hold4", {60'd0, bubble4}, 64'hF);
`endif

    // stream four instructions with downstream always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4));
      tick();
      expect_head($sformatf("stream%0d", i), 32'(i * 4));
      check($sformatf("stream%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, 32'h0); tick();
    expect_empty("stream_drain");

    // backpressure fills skid; a third offer is refused
    out_ready = 1'b0;
    drive(1'b1, 32'h10); tick();
    expect_head("bp_first", 32'h10);
    check("bp_busy_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'h14); tick();
    expect_head("bp_full", 32'h10);
    check("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h18); tick();
    expect_head("bp_refused", 32'h10);
    drive(1'b0, 32'h0); out_ready = 1'b1; tick();
    expect_head("bp_release0", 32'h14);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    expect_empty("bp_release1");

    // flush while FULL with a live input: everything discarded
    out_ready = 1'b0;
    drive(1'b1, 32'h20); tick();
    drive(1'b1, 32'h24); tick();
    check("flush_pre_full", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h28); flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    expect_empty("flush");
    tick();
    expect_empty("flush_after");

    // clock-enable low freezes the stage
    out_ready = 1'b0;
    drive(1'b1, 32'h30); tick();
    ce = 1'b0; drive(1'b1, 32'h34); out_ready = 1'b1;
    #1;
    check("ce0_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_head($sformatf("ce0_hold%0d", i), 32'h30);
    end
    ce = 1'b1; drive(1'b0, 32'h0); tick();
    expect_empty("ce1_drain");

    // async reset in the middle of FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h40); tick();
    drive(1'b1, 32'h44); tick();
    drive(1'b0, 32'h0);
    #2; rst = 1'b1; #1;
    expect_empty("rst_full");
    check("rst_full_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst = 1'b0;
    drive(1'b1, 32'h50); tick();
    drive(1'b0, 32'h0);
    expect_head("post_rst", 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
